ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits between ps2_rx and the game/display logic; consumes each received PS/2 set-2 byte (scan_done_tick + scan_code).
- Resolves E0 (extended) and F0 (break) prefixes and tracks held state for the six game keys.
- Emits per-key held levels plus one-cycle press and release pulses with typematic repeats filtered.
- A prefix watchdog recovers from truncated multi-byte sequences.

Parameters:
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed between a prefix byte and its following byte (20 ms at 100 MHz).
- NUM_KEYS, 6, number of tracked keys; fixed by the key map and not meant to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- scan_done_tick  in  1  one-cycle strobe from ps2_rx: scan_code is valid
- scan_code  in  8  received byte
- clear  in  1  synchronous flush of held state (driven by game reset)
- key_held  out  6  level: key currently down
- key_press  out  6  one-cycle pulse on first make of a key
- key_release  out  6  one-cycle pulse on break of a held key
- proto_err  out  1  one-cycle pulse on watchdog expiry or illegal prefix order

Behaviour:
- Key index map (plain or E0-extended codes map to the same index):
  - 0 left: 1C, or E0 6B
  - 1 right: 23, or E0 74
  - 2 up: 1D, or E0 75
  - 3 down: 1B, or E0 72
  - 4 game_reset: 2D
  - 5 enter: 5A, or E0 5A
- Reset: all outputs 0, FSM in IDLE, watchdog counter 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions happen only on scan_done_tick.
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> make(ext=0, code), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (restart, pulse proto_err); other byte -> make(ext=1, code), go IDLE.
  - BRK: E0 -> EXT (pulse proto_err); F0 -> BRK (pulse proto_err); other byte -> break(ext=0, code), go IDLE.
  - EXT_BRK: E0 or F0 -> pulse proto_err, apply the IDLE rule to the byte; other byte -> break(ext=1, code), go IDLE.
- make: for a mapped key not yet held, set key_held[i] and pulse key_press[i]. If already held (typematic repeat), no change and no pulse. Unmapped codes are ignored.
- break: for a mapped key that is held, clear key_held[i] and pulse key_release[i]. If not held, no pulse. Unmapped codes are ignored.
- Latency: key_held, key_press and key_release update on the clk edge after the scan_done_tick cycle (one-cycle registered). key_press and key_held[i] rise on the same edge.
- Ignored bytes: AA, FA, EE and E1 received in IDLE are ignored. Bytes following E1 decode normally; they are unmapped, so they have no effect.
- Watchdog:
  - Counter clears on every scan_done_tick and counts only while not in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no tick: FSM -> IDLE, proto_err pulse, counter cleared.
  - If a tick arrives in that same cycle, the tick wins: the byte is processed with the current prefix state and no proto_err is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES); it never wraps.
- clear:
  - Next edge: key_held = 0, FSM -> IDLE, counter 0; no release pulses.
  - A scan_done_tick in the same cycle as clear is dropped.
  - Pulses already on the outputs last their one cycle only.
- Multiple keys may be held simultaneously; each index is independent.
- Asynchronous reset mid-sequence discards any prefix. The first byte after reset is decoded from IDLE.

Decomposition:
- Package ps2_key_pkg holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, and the key codes above
  - key index constants: KEY_LEFT..KEY_ENTER
  - NUM_KEYS
  - FSM state encoding, 2 bits
- Sub-module ps2_code_lookup: combinational {ext, code[7:0]} -> {hit, idx[2:0]}. It holds the key map in one place so the FSM stays free of code literals.

Test Plan:
- Reset released, tick 1C -> key_held=000001 and key_press[0] pulses one cycle later; three more 1C ticks -> no further press pulses.
- Ticks E0,75 then E0,F0,75 -> key_held[2] rises with press pulse, then falls with key_release[2] pulse; key_held otherwise 0.
- Ticks 5A, then 23, then F0,5A -> key_held = 100000, then 100010, then 000010; exactly one release pulse, on bit 5.
- Tick E0, then no tick for TIMEOUT_CYCLES (set to 100 in sim) -> proto_err pulse at cycle 99, FSM IDLE; next tick 1B -> make, key_held[3]=1, not an extended decode.
- Ticks F0,1D with up not held -> no release pulse, key_held unchanged; tick F0,E0,6B -> proto_err pulse, then key_held[0]=1.
- Hold keys 0 and 4, assert clear together with a 1C tick -> key_held=0, no release pulses, tick ignored. Pulse reset low mid E0,F0 -> all outputs 0; subsequent 2D -> key_press[4].

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 set-2 key decoder: scan codes, key indices,
// FSM state encoding and the per-byte key action type.
package ps2_key_pkg;

  localparam int NUM_KEYS = 6;

  // Prefix bytes
  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;

  // Plain (non-extended) key codes
  localparam logic [7:0] SC_LEFT       = 8'h1C;
  localparam logic [7:0] SC_RIGHT      = 8'h23;
  localparam logic [7:0] SC_UP         = 8'h1D;
  localparam logic [7:0] SC_DOWN       = 8'h1B;
  localparam logic [7:0] SC_GAME_RESET = 8'h2D;
  localparam logic [7:0] SC_ENTER      = 8'h5A;

  // E0-extended key codes
  localparam logic [7:0] SC_X_LEFT     = 8'h6B;
  localparam logic [7:0] SC_X_RIGHT    = 8'h74;
  localparam logic [7:0] SC_X_UP       = 8'h75;
  localparam logic [7:0] SC_X_DOWN     = 8'h72;
  localparam logic [7:0] SC_X_ENTER    = 8'h5A;

  // Keyboard housekeeping bytes that carry no key information
  localparam logic [7:0] SC_BAT_OK     = 8'hAA;
  localparam logic [7:0] SC_ACK        = 8'hFA;
  localparam logic [7:0] SC_ECHO       = 8'hEE;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;

  // Key indices into key_held / key_press / key_release
  localparam logic [2:0] KEY_LEFT       = 3'd0;
  localparam logic [2:0] KEY_RIGHT      = 3'd1;
  localparam logic [2:0] KEY_UP         = 3'd2;
  localparam logic [2:0] KEY_DOWN       = 3'd3;
  localparam logic [2:0] KEY_GAME_RESET = 3'd4;
  localparam logic [2:0] KEY_ENTER      = 3'd5;

  // Prefix FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // What a completed byte sequence does to the key state
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_MAKE,
    ACT_BREAK
  } key_action_e;

  // Bytes the keyboard sends outside of key sequences; dropped when idle
  function automatic logic is_ignored_code(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK) ||
           (code == SC_ECHO)   || (code == SC_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_code_lookup.sv
// Combinational key map: {extended flag, scan code} -> {hit, key index}.
// Keeps every key-code literal in one place so the decoder FSM never sees them.
module ps2_code_lookup
  import ps2_key_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [2:0] o_idx
);

  // Map the code to a key index; anything not listed is a miss
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_hit = 1'b0;
    o_idx = '0;
    if (i_ext) begin
      case (i_code)
        SC_X_LEFT:  begin o_hit = 1'b1; o_idx = KEY_LEFT;  end
        SC_X_RIGHT: begin o_hit = 1'b1; o_idx = KEY_RIGHT; end
        SC_X_UP:    begin o_hit = 1'b1; o_idx = KEY_UP;    end
        SC_X_DOWN:  begin o_hit = 1'b1; o_idx = KEY_DOWN;  end
        SC_X_ENTER: begin o_hit = 1'b1; o_idx = KEY_ENTER; end
        default:    ;
      endcase
    end else begin
      case (i_code)
        SC_LEFT:       begin o_hit = 1'b1; o_idx = KEY_LEFT;       end
        SC_RIGHT:      begin o_hit = 1'b1; o_idx = KEY_RIGHT;      end
        SC_UP:         begin o_hit = 1'b1; o_idx = KEY_UP;         end
        SC_DOWN:       begin o_hit = 1'b1; o_idx = KEY_DOWN;       end
        SC_GAME_RESET: begin o_hit = 1'b1; o_idx = KEY_GAME_RESET; end
        SC_ENTER:      begin o_hit = 1'b1; o_idx = KEY_ENTER;      end
        default:       ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: resolves E0/F0 prefixes, tracks held state for the
// game keys, emits press/release pulses with typematic repeats filtered, and
// recovers from truncated prefix sequences with a watchdog.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_done_tick,
  input  logic [7:0]          scan_code,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                proto_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic                r_err;

  logic [1:0]          w_next_state;
  key_action_e         w_action;
  logic                w_ext;
  logic                w_prefix_err;
  logic                w_timeout;
  logic                w_hit;
  logic [2:0]          w_idx;
  logic [NUM_KEYS-1:0] w_onehot;

  ps2_code_lookup u_lookup (
    .i_ext  (w_ext),
    .i_code (scan_code),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Prefix decode: next state and key action for the byte on scan_code
  always_comb begin
    w_next_state = r_state;
    w_action     = ACT_NONE;
    w_ext        = 1'b0;
    w_prefix_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (scan_code == SC_EXT)           w_next_state = ST_EXT;
        else if (scan_code == SC_BRK)      w_next_state = ST_BRK;
        else if (!is_ignored_code(scan_code)) w_action  = ACT_MAKE;
      end
      ST_EXT: begin
        if (scan_code == SC_BRK) begin
          w_next_state = ST_EXT_BRK;
        end else if (scan_code == SC_EXT) begin
          w_next_state = ST_EXT;
          w_prefix_err = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
          w_action     = ACT_MAKE;
          w_ext        = 1'b1;
        end
      end
      ST_BRK: begin
        if (scan_code == SC_EXT) begin
          w_next_state = ST_EXT;
          w_prefix_err = 1'b1;
        end else if (scan_code == SC_BRK) begin
          w_next_state = ST_BRK;
          w_prefix_err = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
          w_action     = ACT_BREAK;
        end
      end
      default: begin  // ST_EXT_BRK: a stray prefix restarts from the idle rule
        if (scan_code == SC_EXT) begin
          w_next_state = ST_EXT;
          w_prefix_err = 1'b1;
        end else if (scan_code == SC_BRK) begin
          w_next_state = ST_BRK;
          w_prefix_err = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
          w_action     = ACT_BREAK;
          w_ext        = 1'b1;
        end
      end
    endcase
  end

  // Expand the looked-up key index into a one-hot key mask
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_onehot[i] = w_hit && (w_idx == 3'(i));
    end
  end

  // A tick arriving on the expiry cycle wins over the watchdog
  assign w_timeout = !scan_done_tick && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

  // Prefix FSM, watchdog counter and protocol-error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_err <= 1'b0;
      if (clear) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (scan_done_tick) begin
        r_state <= w_next_state;
        r_cnt   <= '0;
        r_err   <= w_prefix_err;
      end else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_err   <= 1'b1;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Held levels plus one-cycle press/release pulses; repeats change nothing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      if (clear) begin
        r_held <= '0;
      end else if (scan_done_tick) begin
        if (w_action == ACT_MAKE) begin
          r_press <= w_onehot & ~r_held;
          r_held  <= r_held | w_onehot;
        end else if (w_action == ACT_BREAK) begin
          r_release <= w_onehot & r_held;
          r_held    <= r_held & ~w_onehot;
        end
      end
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign proto_err   = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with a short watchdog.
module tb_ps2_key_decoder;

  logic       clk;
  logic       reset;
  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic       clear;
  logic [5:0] key_held;
  logic [5:0] key_press;
  logic [5:0] key_release;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .clear          (clear),
    .key_held       (key_held),
    .key_press      (key_press),
    .key_release    (key_release),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle tick; returns on the falling edge after the decoding edge
  task automatic send(input logic [7:0] code);
    @(negedge clk);
    scan_done_tick = 1'b1;
    scan_code      = code;
    @(negedge clk);
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] held,
                            input logic [5:0] press, input logic [5:0] rel,
                            input logic err);
    check({tag, ".held"},    32'(key_held),    32'(held));
    check({tag, ".press"},   32'(key_press),   32'(press));
    check({tag, ".release"}, 32'(key_release), 32'(rel));
    check({tag, ".err"},     32'(proto_err),   32'(err));
  endtask

  initial begin
    reset          = 1'b0;
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
    clear          = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 6'b000000, 6'b000000, 6'b000000, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Plain make of left, then typematic repeats
    send(8'h1C);
    check_outs("make_left", 6'b000001, 6'b000001, 6'b000000, 1'b0);
    @(negedge clk);
    check_outs("make_left_after", 6'b000001, 6'b000000, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(8'h1C);
      check_outs("repeat_left", 6'b000001, 6'b000000, 6'b000000, 1'b0);
    end
    send(8'hF0);
    check_outs("brk_prefix", 6'b000001, 6'b000000, 6'b000000, 1'b0);
    send(8'h1C);
    check_outs("break_left", 6'b000000, 6'b000000, 6'b000001, 1'b0);

    // Extended up: make then break
    send(8'hE0);
    send(8'h75);
    check_outs("ext_make_up", 6'b000100, 6'b000100, 6'b000000, 1'b0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_outs("ext_break_up", 6'b000000, 6'b000000, 6'b000100, 1'b0);

    // Two keys held, release only enter
    send(8'h5A);
    check_outs("make_enter", 6'b100000, 6'b100000, 6'b000000, 1'b0);
    send(8'h23);
    check_outs("make_right", 6'b100010, 6'b000010, 6'b000000, 1'b0);
    send(8'hF0);
    send(8'h5A);
    check_outs("break_enter", 6'b000010, 6'b000000, 6'b100000, 1'b0);
    @(negedge clk);
    check_outs("break_enter_after", 6'b000010, 6'b000000, 6'b000000, 1'b0);
    send(8'hF0);
    send(8'h23);
    check_outs("break_right", 6'b000000, 6'b000000, 6'b000010, 1'b0);

    // Watchdog expiry after a lone E0: counter hits 99 after 99 idle edges,
    // expiry is registered on the following edge
    send(8'hE0);
    repeat (99) @(negedge clk);
    check("wdog_before", 32'(proto_err), 32'd0);
    @(negedge clk);
    check("wdog_expire", 32'(proto_err), 32'd1);
    @(negedge clk);
    check("wdog_pulse_len", 32'(proto_err), 32'd0);
    send(8'h1B);
    check_outs("after_wdog_down", 6'b001000, 6'b001000, 6'b000000, 1'b0);

    // Tick on the expiry cycle wins: E0 6B decodes as extended left
    send(8'hE0);
    repeat (98) @(negedge clk);
    send(8'h6B);
    check_outs("wdog_tick_wins", 6'b001001, 6'b000001, 6'b000000, 1'b0);
    send(8'hF0);
    send(8'h1C);
    check_outs("release_left", 6'b001000, 6'b000000, 6'b000001, 1'b0);

    // Break of a key that is not held; then illegal prefix order
    send(8'hF0);
    send(8'h1D);
    check_outs("break_unheld", 6'b001000, 6'b000000, 6'b000000, 1'b0);
    send(8'hF0);
    send(8'hE0);
    check_outs("brk_then_ext", 6'b001000, 6'b000000, 6'b000000, 1'b1);
    send(8'h6B);
    check_outs("ext_left_recover", 6'b001001, 6'b000001, 6'b000000, 1'b0);

    // clear drops a coincident tick and leaves no prefix behind
    send(8'h2D);
    check_outs("make_game_reset", 6'b011001, 6'b010000, 6'b000000, 1'b0);
    send(8'hE0);
    @(negedge clk);
    clear          = 1'b1;
    scan_done_tick = 1'b1;
    scan_code      = 8'h1C;
    @(negedge clk);
    clear          = 1'b0;
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
    check_outs("clear", 6'b000000, 6'b000000, 6'b000000, 1'b0);
    @(negedge clk);
    check_outs("clear_after", 6'b000000, 6'b000000, 6'b000000, 1'b0);
    send(8'h1C);
    check_outs("make_after_clear", 6'b000001, 6'b000001, 6'b000000, 1'b0);

    // Async reset in the middle of E0 F0; next byte decodes from idle
    send(8'hE0);
    send(8'hF0);
    #2 reset = 1'b0;
    #1;
    check_outs("async_reset", 6'b000000, 6'b000000, 6'b000000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    send(8'h2D);
    check_outs("post_reset_make", 6'b010000, 6'b010000, 6'b000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
